// File: rtl/nibble_serial_cla_subtractor_pkg.sv
// Shared constants and types for the nibble-serial CLA subtractor.
// The slice width is fixed at one nibble.
package nibble_serial_cla_subtractor_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_cla_subtractor_cla4.sv
// 4-bit carry-lookahead adder slice.
// Reused every cycle by the nibble-serial subtractor.
module four_bit_CLA_adder_verilog (
    input  logic [3:0] i_A,
    input  logic [3:0] i_B,
    input  logic       i_Cin,
    output logic [3:0] o_Sum,
    output logic       o_Cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = i_A ^ i_B;
    assign g = i_A & i_B;

    assign c[0] = i_Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign o_Sum  = p ^ c[3:0];
    assign o_Cout = c[4];

endmodule

// File: rtl/nibble_serial_cla_subtractor.sv
// Multi-cycle subtractor: A - B - Bin computed as A + ~B + ~Bin,
// one nibble per cycle through a single shared CLA slice.
module nibble_serial_cla_subtractor
    import nibble_serial_cla_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Bin,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Diff,
    output logic             o_Bout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = cnt_w(NIBBLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bn_reg;
    logic            carry_reg;
    logic            rdy_en;
    logic            accept;
    logic            step;
    logic            last;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      sum;
    logic            cout;

    assign a_nib = a_reg[cnt*NIBBLE_W +: NIBBLE_W];
    assign b_nib = bn_reg[cnt*NIBBLE_W +: NIBBLE_W];
    assign last  = (cnt == CNT_LAST);

    four_bit_CLA_adder_verilog u_slice (
        .i_A   (a_nib),
        .i_B   (b_nib),
        .i_Cin (carry_reg),
        .o_Sum (sum),
        .o_Cout(cout)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        o_Ready  = 1'b0;
        o_Valid  = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_Ready = rdy_en;
                if (i_Valid && rdy_en) begin
                    accept   = 1'b1;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                o_Valid = 1'b1;
                if (i_Ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // rdy_en keeps o_Ready low until the first edge after reset release
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rdy_en    <= 1'b0;
            cnt       <= '0;
            a_reg     <= '0;
            bn_reg    <= '0;
            carry_reg <= 1'b0;
            o_Diff    <= '0;
            o_Bout    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                a_reg     <= i_A;
                bn_reg    <= ~i_B;
                carry_reg <= ~i_Bin;
                cnt       <= '0;
            end else if (step) begin
                o_Diff[cnt*NIBBLE_W +: NIBBLE_W] <= sum;
                carry_reg <= cout;
                cnt       <= cnt + 1'b1;
                if (last) begin
                    o_Bout <= ~cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_cla_subtractor.sv
// Self-checking bench: directed and random operations on a 16-bit
// instance plus an exhaustive sweep of a 4-bit instance.
module tb_nibble_serial_cla_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        v16, r16, ov16, ir16, bin16, bo16;
    logic [15:0] a16, b16, d16;
    logic        v4, r4, ov4, ir4, bin4, bo4;
    logic [3:0]  a4, b4, d4;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    nibble_serial_cla_subtractor #(.WIDTH(16)) dut16 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_Valid(v16), .o_Ready(r16),
        .i_A(a16), .i_B(b16), .i_Bin(bin16),
        .o_Valid(ov16), .i_Ready(ir16),
        .o_Diff(d16), .o_Bout(bo16)
    );

    nibble_serial_cla_subtractor #(.WIDTH(4)) dut4 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_Valid(v4), .o_Ready(r4),
        .i_A(a4), .i_B(b4), .i_Bin(bin4),
        .o_Valid(ov4), .i_Ready(ir4),
        .o_Diff(d4), .o_Bout(bo4)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_diff(input int a, input int b,
                                             input int bin, input int w);
        int d;
        d = a - b - bin;
        return 32'(d) & ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic ref_bout(input int a, input int b, input int bin);
        return a < (b + bin);
    endfunction

    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input int hold, input string tag);
        int lat;
        logic [15:0] ed;
        logic eb;
        ed = ref_diff(int'(a), int'(b), int'(bin), 16);
        eb = ref_bout(int'(a), int'(b), int'(bin));
        @(negedge clk);
        ir16 = 1'b0;
        chk({tag, "_ready"}, 32'(r16), 32'd1);
        v16 = 1'b1; a16 = a; b16 = b; bin16 = bin;
        @(posedge clk); #1;
        lat = 0;
        while (lat < 20) begin
            v16 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            bin16 = 1'($urandom);
            ir16 = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (ov16) break;
        end
        v16 = 1'b0; ir16 = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_diff"}, 32'(d16), 32'(ed));
        chk({tag, "_bout"}, 32'(bo16), 32'(eb));
        chk({tag, "_busy_rdy"}, 32'(r16), 32'd0);
        for (int i = 0; i < hold; i++) begin
            v16 = 1'($urandom); a16 = 16'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold"}, {14'd0, ov16, r16, d16}, {14'd0, 2'b10, ed});
            chk({tag, "_hold_b"}, 32'(bo16), 32'(eb));
        end
        v16 = 1'b0; ir16 = 1'b1;
        @(posedge clk); #1;
        ir16 = 1'b0;
        chk({tag, "_rel"}, {15'd0, ov16, d16}, {15'd0, 1'b0, ed});
        chk({tag, "_rel_b"}, 32'(bo16), 32'(eb));
        chk({tag, "_idle_rdy"}, 32'(r16), 32'd1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic bin);
        int lat;
        @(negedge clk);
        v4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
        @(posedge clk); #1;
        lat = 0;
        while (lat < 10) begin
            v4 = 1'($urandom); a4 = 4'($urandom);
            b4 = 4'($urandom); bin4 = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (ov4) break;
        end
        v4 = 1'b0;
        chk("w4_lat", 32'(lat), 32'd1);
        chk($sformatf("w4_diff_%0h_%0h_%0d", a, b, bin), 32'(d4),
            ref_diff(int'(a), int'(b), int'(bin), 4));
        chk($sformatf("w4_bout_%0h_%0h_%0d", a, b, bin), 32'(bo4),
            32'(ref_bout(int'(a), int'(b), int'(bin))));
        ir4 = 1'b1;
        @(posedge clk); #1;
        ir4 = 1'b0;
    endtask

    initial begin
        v16 = 0; ir16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        v4 = 0; ir4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        #12;
        chk("rst_out", {13'd0, ov16, r16, bo16, d16}, 32'd0);
        chk("rst_w4", {26'd0, ov4, r4, bo4, d4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_low", 32'(r16), 32'd0);
        @(posedge clk); #1;
        chk("rel_rdy_high", 32'(r16), 32'd1);

        op16(16'h1234, 16'h0123, 1'b0, 0, "t1");
        op16(16'h1000, 16'h0001, 1'b0, 0, "t2");
        op16(16'h0000, 16'h0001, 1'b0, 0, "t3a");
        op16(16'h0005, 16'h0005, 1'b1, 0, "t3b");
        op16(16'hBEEF, 16'h1234, 1'b1, 5, "t4");
        op16(16'h8000, 16'h7FFF, 1'b0, 0, "t4n");

        @(negedge clk);
        v16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; bin16 = 1'b0;
        @(posedge clk); #1;
        v16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst", {13'd0, ov16, r16, bo16, d16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op16(16'hFFFF, 16'hFFFF, 1'b0, 0, "t5");

        for (int i = 0; i < 30; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom),
                 int'($urandom_range(0, 2)), "rnd");
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    op4(4'(a), 4'(b), 1'(c));
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
